instr_decode_stage: RTL and testbench
=====================================

# instr_decode_stage

Pipelined RV32I instruction decode stage. It sits directly downstream of instruction fetch and consumes raw 32-bit instruction words with their PC over a valid/ready handshake. For each instruction it produces a one-hot opcode, the instruction format, register indices, function fields and a sign-extended immediate, all typed with the `riscv_pkg` enums and structs. Its output is a registered, fully backpressurable stream with a 2-entry skid buffer that feeds register read / execute.

## Interface
- XLEN, default 32: data/PC width; only 32 is supported.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous kill of all buffered instructions.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  stage can accept; registered.
- in_instr  in  32  raw instruction word.
- in_pc  in  XLEN  PC of in_instr.
- out_valid  out  1  decoded instruction available.
- out_ready  in  1  downstream accepts.
- out_pc  out  XLEN  PC passthrough.
- out_opcode  out  11  `opcode_1hot_struct_t`; all zero for an unknown opcode.
- out_fmt  out  3  `instr_formats_e`.
- out_rd, out_rs1, out_rs2  out  5 each  fields instr[11:7], instr[19:15], instr[24:20].
- out_funct3  out  3  instr[14:12].
- out_funct7  out  7  instr[31:25].
- out_imm  out  32  sign-extended immediate.
- out_illegal  out  1  illegal-instruction flag; see Configuration.

## Operation
- Handshakes:
  - An input transfer occurs when `in_valid && in_ready`.
  - An output transfer occurs when `out_valid && out_ready`.
- Format mapping:
  - LUI, AUIPC → U_type.
  - JAL → J_type.
  - JALR, LOAD, RI, FENCE, EXCPT → I_type.
  - BRANCH → B_type.
  - STORE → S_type.
  - RR → R_type.
  - Any other opcode → NONE_t.
- Immediate:
  - I: sext(i[31:20]).
  - S: sext({i[31:25], i[11:7]}).
  - B: sext({i[31], i[7], i[30:25], i[11:8], 1'b0}).
  - U: {i[31:12], 12'b0}.
  - J: sext({i[31], i[19:12], i[20], i[30:21], 1'b0}).
  - R and NONE_t: 0.
- Register and function fields are always extracted, whatever the format.
- Buffering uses two entries: the main output register and a skid register.
  - State EMPTY: out_valid=0, in_ready=1.
  - State ONE: main register valid, in_ready=1.
  - State FULL: both registers valid, in_ready=0.
- Transitions:
  - EMPTY + input → ONE.
  - ONE + input + output → ONE (main register reloads).
  - ONE + input, no output → FULL (input goes to skid).
  - ONE + output, no input → EMPTY.
  - FULL + output → ONE (skid moves to main).
- Order is strictly preserved. No instruction is dropped or duplicated.

## Timing
- Latency: an instruction accepted at edge N appears on the outputs after edge N, i.e. out_valid is high in cycle N+1.
- Throughput: 1 instruction per cycle while out_ready=1.
- in_ready depends only on registered state, with no combinational path from out_ready.
- Outputs are stable while `out_valid && !out_ready`.
- flush:
  - At the next edge both entries are invalidated and the state goes to EMPTY.
  - Any input transfer in the flush cycle is discarded.
  - flush has priority over all transitions.
- Reset values:
  - out_valid=0, in_ready=1.
  - out_fmt=NONE_t, out_opcode=0, out_illegal=0.
  - All other data outputs 0.
- Reset asserted mid-stream discards all contents immediately (asynchronously).

## Configuration
- Macro: `RISCV_DECODE_ILLEGAL_CHK_EN`.
- When defined, out_illegal=1 if any of the following holds:
  - i[1:0] != 2'b11.
  - The opcode is unknown.
  - RR has funct7 not 0000000, other than 0100000 with funct3 000 or 101.
  - RI with funct3 001 has funct7 != 0.
  - RI with funct3 101 has funct7 not 0000000 or 0100000.
- An illegal instruction still flows through the stage with its decoded fields.
- When not defined, out_illegal is tied to 0 and no check logic is built.

## Structure
- `riscv_pkg` gains:
  - localparams for the field bit positions (RD_LSB, RS1_LSB, RS2_LSB, FUNCT7_LSB).
  - `decoded_instr_t`, a packed struct holding pc, opcode, fmt, rd, rs1, rs2, funct3, funct7, imm and illegal; both buffer entries store this type.
- One sub-module: `instr_decode_comb`, the pure combinational decode from instruction to `decoded_instr_t`. The top level holds the skid buffer and control.

## Test plan
- Input 0x00500093 (addi x1,x0,5) at pc 0x100 → one cycle later: RI bit set, fmt=I_type, rd=1, rs1=0, imm=0x00000005, illegal=0.
- Input 0xFE112E23 (sw x1,-4(x2)) → fmt=S_type, rs1=2, rs2=1, funct3=010, imm=0xFFFFFFFC.
- Input 0x008000EF (jal x1,+8) → fmt=J_type, rd=1, imm=0x00000008. Input 0x123452B7 (lui) → fmt=U_type, imm=0x12345000.
- Four back-to-back inputs with out_ready low for 3 cycles → in_ready drops after the second acceptance, then all four emerge in order with no loss.
- Input 0x00000000 → with the macro defined: out_illegal=1, fmt=NONE_t, out_opcode=0. Without it: out_illegal=0.
- Stage in FULL when flush is pulsed → next cycle out_valid=0 and in_ready=1. Async reset mid-transfer → outputs return to their reset values immediately.

Source files
------------

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared RV32I decode types.
//   - field bit positions of the instruction word
//   - major opcode values
//   - opcode_1hot_struct_t, instr_formats_e, decoded_instr_t
//   - buffer state encoding of the decode stage
// The illegal-instruction check in instr_decode_comb is built only when
// RISCV_DECODE_ILLEGAL_CHK_EN is defined; these types are the same either way.
package riscv_pkg;

  localparam int RV_XLEN    = 32;

  localparam int RD_LSB     = 7;
  localparam int FUNCT3_LSB = 12;
  localparam int RS1_LSB    = 15;
  localparam int RS2_LSB    = 20;
  localparam int FUNCT7_LSB = 25;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_RI     = 7'b0010011;
  localparam logic [6:0] OPC_RR     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_EXCPT  = 7'b1110011;

  typedef enum logic [2:0] {
    NONE_t = 3'd0,
    R_type = 3'd1,
    I_type = 3'd2,
    S_type = 3'd3,
    B_type = 3'd4,
    U_type = 3'd5,
    J_type = 3'd6
  } instr_formats_e;

  typedef struct packed {
    logic lui;
    logic auipc;
    logic jal;
    logic jalr;
    logic branch;
    logic load;
    logic store;
    logic ri;
    logic rr;
    logic fence;
    logic excpt;
  } opcode_1hot_struct_t;

  typedef struct packed {
    logic [RV_XLEN-1:0]  pc;
    opcode_1hot_struct_t opcode;
    instr_formats_e      fmt;
    logic [4:0]          rd;
    logic [4:0]          rs1;
    logic [4:0]          rs2;
    logic [2:0]          funct3;
    logic [6:0]          funct7;
    logic [31:0]         imm;
    logic                illegal;
  } decoded_instr_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } buf_state_e;

endpackage

// File: rtl/instr_decode_comb.sv
// instr_decode_comb: purely combinational RV32I decode of one instruction.
// Ports:
//   instr_i  raw 32-bit instruction word
//   pc_i     PC of instr_i, passed through
//   dec_o    decoded_instr_t (one-hot opcode, format, fields, immediate,
//            illegal flag)
// Macro RISCV_DECODE_ILLEGAL_CHK_EN: when defined, builds the illegal
// encoding check; otherwise dec_o.illegal is constant 0.
module instr_decode_comb
  import riscv_pkg::*;
(
  input  logic [31:0]  instr_i,
  input  logic [31:0]  pc_i,
  output decoded_instr_t dec_o
);

  opcode_1hot_struct_t opc;
  instr_formats_e      fmt;
  logic [31:0]         imm;
  logic [2:0]          f3;
  logic [6:0]          f7;
  logic                illegal;

  assign f3 = instr_i[FUNCT3_LSB +: 3];
  assign f7 = instr_i[FUNCT7_LSB +: 7];

  always_comb begin
    opc = '0;
    fmt = NONE_t;
    case (instr_i[6:0])
      OPC_LUI:    begin opc.lui    = 1'b1; fmt = U_type; end
      OPC_AUIPC:  begin opc.auipc  = 1'b1; fmt = U_type; end
      OPC_JAL:    begin opc.jal    = 1'b1; fmt = J_type; end
      OPC_JALR:   begin opc.jalr   = 1'b1; fmt = I_type; end
      OPC_BRANCH: begin opc.branch = 1'b1; fmt = B_type; end
      OPC_LOAD:   begin opc.load   = 1'b1; fmt = I_type; end
      OPC_STORE:  begin opc.store  = 1'b1; fmt = S_type; end
      OPC_RI:     begin opc.ri     = 1'b1; fmt = I_type; end
      OPC_RR:     begin opc.rr     = 1'b1; fmt = R_type; end
      OPC_FENCE:  begin opc.fence  = 1'b1; fmt = I_type; end
      OPC_EXCPT:  begin opc.excpt  = 1'b1; fmt = I_type; end
      default:    begin opc = '0;          fmt = NONE_t; end
    endcase
  end

  always_comb begin
    imm = '0;
    case (fmt)
      I_type:  imm = {{20{instr_i[31]}}, instr_i[31:20]};
      S_type:  imm = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      B_type:  imm = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                      instr_i[30:25], instr_i[11:8], 1'b0};
      U_type:  imm = {instr_i[31:12], 12'b0};
      J_type:  imm = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                      instr_i[20], instr_i[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

`ifdef RISCV_DECODE_ILLEGAL_CHK_EN
  always_comb begin
    illegal = 1'b0;
    if (instr_i[1:0] != 2'b11) illegal = 1'b1;
    if (opc == '0) illegal = 1'b1;
    // Only SUB and SRA may use the alternate funct7.
    if (opc.rr && (f7 != 7'b0000000) &&
        !((f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101))))
      illegal = 1'b1;
    if (opc.ri && (f3 == 3'b001) && (f7 != 7'b0000000)) illegal = 1'b1;
    if (opc.ri && (f3 == 3'b101) &&
        (f7 != 7'b0000000) && (f7 != 7'b0100000))
      illegal = 1'b1;
  end
`else
  assign illegal = 1'b0;
`endif

  always_comb begin
    dec_o         = '0;
    dec_o.pc      = pc_i;
    dec_o.opcode  = opc;
    dec_o.fmt     = fmt;
    dec_o.rd      = instr_i[RD_LSB  +: 5];
    dec_o.rs1     = instr_i[RS1_LSB +: 5];
    dec_o.rs2     = instr_i[RS2_LSB +: 5];
    dec_o.funct3  = f3;
    dec_o.funct7  = f7;
    dec_o.imm     = imm;
    dec_o.illegal = illegal;
  end

endmodule

// File: rtl/instr_decode_stage.sv
// instr_decode_stage: pipelined RV32I decode stage with a 2-entry skid
// buffer (main output register + skid register).
// Ports:
//   clk, rst_n (async, active-low), flush (sync kill of buffered entries)
//   in_valid/in_ready/in_instr/in_pc      fetch side handshake
//   out_valid/out_ready                   downstream handshake
//   out_pc, out_opcode, out_fmt, out_rd, out_rs1, out_rs2, out_funct3,
//   out_funct7, out_imm, out_illegal      decoded fields of the main entry
// Macro RISCV_DECODE_ILLEGAL_CHK_EN: enables the illegal-encoding check in
// instr_decode_comb; without it out_illegal is always 0.
//
// state    | meaning
// ---------+-------------------------------------------
// ST_EMPTY | nothing buffered, out_valid=0, in_ready=1
// ST_ONE   | main register valid, in_ready=1
// ST_FULL  | main and skid valid, in_ready=0
module instr_decode_stage
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [31:0]         in_instr,
  input  logic [XLEN-1:0]     in_pc,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [XLEN-1:0]     out_pc,
  output opcode_1hot_struct_t out_opcode,
  output instr_formats_e      out_fmt,
  output logic [4:0]          out_rd,
  output logic [4:0]          out_rs1,
  output logic [4:0]          out_rs2,
  output logic [2:0]          out_funct3,
  output logic [6:0]          out_funct7,
  output logic [31:0]         out_imm,
  output logic                out_illegal
);

  buf_state_e     state_q, state_d;
  decoded_instr_t main_q, main_d;
  decoded_instr_t skid_q, skid_d;
  decoded_instr_t dec;
  logic           in_xfer, out_xfer;

  instr_decode_comb u_decode (
    .instr_i (in_instr),
    .pc_i    (in_pc),
    .dec_o   (dec)
  );

  // Both handshake flags come straight from the state register, so there is
  // no combinational path from out_ready to in_ready.
  assign in_ready  = (state_q != ST_FULL);
  assign out_valid = (state_q != ST_EMPTY);
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_xfer) begin
            main_d  = dec;
            state_d = ST_ONE;
          end
        end
        ST_ONE: begin
          if (in_xfer && out_xfer) begin
            main_d = dec;
          end else if (in_xfer) begin
            skid_d  = dec;
            state_d = ST_FULL;
          end else if (out_xfer) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (out_xfer) begin
            main_d  = skid_q;
            state_d = ST_ONE;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  assign out_pc      = main_q.pc;
  assign out_opcode  = main_q.opcode;
  assign out_fmt     = main_q.fmt;
  assign out_rd      = main_q.rd;
  assign out_rs1     = main_q.rs1;
  assign out_rs2     = main_q.rs2;
  assign out_funct3  = main_q.funct3;
  assign out_funct7  = main_q.funct7;
  assign out_imm     = main_q.imm;
  assign out_illegal = main_q.illegal;

endmodule

// File: tb/tb_instr_decode_stage.sv
// Testbench for instr_decode_stage: directed instructions with hand-computed
// decode results pushed into a scoreboard queue at acceptance; a monitor pops
// and compares on every output transfer.
module tb_instr_decode_stage;
  import riscv_pkg::*;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                flush = 1'b0;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic [31:0]         in_instr = '0;
  logic [31:0]         in_pc = '0;
  logic                out_valid;
  logic                out_ready = 1'b0;
  logic [31:0]         out_pc;
  opcode_1hot_struct_t out_opcode;
  instr_formats_e      out_fmt;
  logic [4:0]          out_rd, out_rs1, out_rs2;
  logic [2:0]          out_funct3;
  logic [6:0]          out_funct7;
  logic [31:0]         out_imm;
  logic                out_illegal;

  int errors = 0;
  int checks = 0;
  decoded_instr_t exp_q[$];
  decoded_instr_t mon_act, mon_exp;

`ifdef RISCV_DECODE_ILLEGAL_CHK_EN
  localparam logic ILL = 1'b1;
`else
  localparam logic ILL = 1'b0;
`endif

  localparam opcode_1hot_struct_t OH_NONE   = '{default: 1'b0};
  localparam opcode_1hot_struct_t OH_LUI    = '{lui: 1'b1,    default: 1'b0};
  localparam opcode_1hot_struct_t OH_AUIPC  = '{auipc: 1'b1,  default: 1'b0};
  localparam opcode_1hot_struct_t OH_JAL    = '{jal: 1'b1,    default: 1'b0};
  localparam opcode_1hot_struct_t OH_JALR   = '{jalr: 1'b1,   default: 1'b0};
  localparam opcode_1hot_struct_t OH_BRANCH = '{branch: 1'b1, default: 1'b0};
  localparam opcode_1hot_struct_t OH_LOAD   = '{load: 1'b1,   default: 1'b0};
  localparam opcode_1hot_struct_t OH_STORE  = '{store: 1'b1,  default: 1'b0};
  localparam opcode_1hot_struct_t OH_RI     = '{ri: 1'b1,     default: 1'b0};
  localparam opcode_1hot_struct_t OH_RR     = '{rr: 1'b1,     default: 1'b0};
  localparam opcode_1hot_struct_t OH_FENCE  = '{fence: 1'b1,  default: 1'b0};
  localparam opcode_1hot_struct_t OH_EXCPT  = '{excpt: 1'b1,  default: 1'b0};

  instr_decode_stage #(.XLEN(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .in_pc       (in_pc),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_pc      (out_pc),
    .out_opcode  (out_opcode),
    .out_fmt     (out_fmt),
    .out_rd      (out_rd),
    .out_rs1     (out_rs1),
    .out_rs2     (out_rs2),
    .out_funct3  (out_funct3),
    .out_funct7  (out_funct7),
    .out_imm     (out_imm),
    .out_illegal (out_illegal)
  );

  always #5 clk = ~clk;

  // Register/function fields are plain bit slices of the word; the opcode,
  // format and immediate are given by hand per vector.
  function automatic decoded_instr_t mk(input logic [31:0] instr,
                                        input logic [31:0] pc,
                                        input opcode_1hot_struct_t op,
                                        input instr_formats_e fmt,
                                        input logic [31:0] imm,
                                        input logic ill);
    decoded_instr_t e;
    e.pc      = pc;
    e.opcode  = op;
    e.fmt     = fmt;
    e.rd      = instr[11:7];
    e.rs1     = instr[19:15];
    e.rs2     = instr[24:20];
    e.funct3  = instr[14:12];
    e.funct7  = instr[31:25];
    e.imm     = imm;
    e.illegal = ill;
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Called one time unit after a rising edge; returns one unit after the
  // edge at which the instruction was accepted.
  task automatic send(input logic [31:0] instr, input logic [31:0] pc,
                      input opcode_1hot_struct_t op, input instr_formats_e fmt,
                      input logic [31:0] imm, input logic ill, input bit push);
    int n = 0;
    in_valid = 1'b1;
    in_instr = instr;
    in_pc    = pc;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout instr=%h in_ready stayed 0 required 1", instr);
      in_valid = 1'b0;
      return;
    end
    if (push) exp_q.push_back(mk(instr, pc, op, fmt, imm, ill));
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk(name, 64'(exp_q.size()), 64'd0);
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      mon_act.pc      = out_pc;
      mon_act.opcode  = out_opcode;
      mon_act.fmt     = out_fmt;
      mon_act.rd      = out_rd;
      mon_act.rs1     = out_rs1;
      mon_act.rs2     = out_rs2;
      mon_act.funct3  = out_funct3;
      mon_act.funct7  = out_funct7;
      mon_act.imm     = out_imm;
      mon_act.illegal = out_illegal;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL spurious_output actual=%h required=no output", mon_act);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_act !== mon_exp) begin
          errors++;
          $display("FAIL decode pc=%h actual=%h required=%h",
                   mon_exp.pc, mon_act, mon_exp);
        end
      end
    end
  end

  initial begin
    #12;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready",  64'(in_ready),  64'd1);
    chk("rst_fmt",       64'(out_fmt),   64'(NONE_t));
    chk("rst_opcode",    64'(out_opcode), 64'd0);
    chk("rst_illegal",   64'(out_illegal), 64'd0);
    chk("rst_pc",        64'(out_pc),    64'd0);
    chk("rst_imm",       64'(out_imm),   64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Streaming, out_ready held high.
    out_ready = 1'b1;
    send(32'h00500093, 32'h100, OH_RI,     I_type, 32'h00000005, 1'b0, 1);
    send(32'hFE112E23, 32'h104, OH_STORE,  S_type, 32'hFFFFFFFC, 1'b0, 1);
    send(32'h008000EF, 32'h108, OH_JAL,    J_type, 32'h00000008, 1'b0, 1);
    send(32'h123452B7, 32'h10C, OH_LUI,    U_type, 32'h12345000, 1'b0, 1);
    send(32'h00208463, 32'h110, OH_BRANCH, B_type, 32'h00000008, 1'b0, 1);
    send(32'h402081B3, 32'h114, OH_RR,     R_type, 32'h00000000, 1'b0, 1);
    send(32'h4032D293, 32'h118, OH_RI,     I_type, 32'h00000403, 1'b0, 1);
    send(32'h022081B3, 32'h11C, OH_RR,     R_type, 32'h00000000, ILL,  1);
    send(32'h00000000, 32'h120, OH_NONE,   NONE_t, 32'h00000000, ILL,  1);
    send(32'h00000073, 32'h124, OH_EXCPT,  I_type, 32'h00000000, 1'b0, 1);
    send(32'h0FF0000F, 32'h128, OH_FENCE,  I_type, 32'h000000FF, 1'b0, 1);
    drain("stream_drain");

    // Four back-to-back with out_ready low for three cycles.
    out_ready = 1'b0;
    fork
      begin
        send(32'hFE000EE3, 32'h200, OH_BRANCH, B_type, 32'hFFFFFFFC, 1'b0, 1);
        send(32'h000080E7, 32'h204, OH_JALR,   I_type, 32'h00000000, 1'b0, 1);
        send(32'hFF812303, 32'h208, OH_LOAD,   I_type, 32'hFFFFFFF8, 1'b0, 1);
        send(32'h00001517, 32'h20C, OH_AUIPC,  U_type, 32'h00001000, 1'b0, 1);
      end
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
      begin
        @(posedge clk); #2;
        chk("bp_in_ready_after_first", 64'(in_ready), 64'd1);
        @(posedge clk); #2;
        chk("bp_in_ready_after_second", 64'(in_ready), 64'd0);
      end
    join
    drain("bp_drain");

    // Flush from FULL.
    out_ready = 1'b0;
    send(32'h00100113, 32'h300, OH_RI, I_type, 32'h1, 1'b0, 0);
    send(32'h00200193, 32'h304, OH_RI, I_type, 32'h2, 1'b0, 0);
    chk("full_in_ready", 64'(in_ready), 64'd0);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    chk("flush_in_ready",  64'(in_ready),  64'd1);

    // Flush in ONE with a simultaneous input: the input is dropped too.
    send(32'h00300213, 32'h308, OH_RI, I_type, 32'h3, 1'b0, 0);
    chk("one_out_valid", 64'(out_valid), 64'd1);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_instr = 32'h00400293;
    in_pc    = 32'h30C;
    @(posedge clk); #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("flush_drop_input", 64'(out_valid), 64'd0);
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Async reset while an entry is held.
    out_ready = 1'b0;
    send(32'h123452B7, 32'h400, OH_LUI, U_type, 32'h12345000, 1'b0, 0);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_in_ready",  64'(in_ready),  64'd1);
    chk("arst_pc",        64'(out_pc),    64'd0);
    chk("arst_imm",       64'(out_imm),   64'd0);
    chk("arst_fmt",       64'(out_fmt),   64'(NONE_t));
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    out_ready = 1'b1;
    send(32'h008000EF, 32'h500, OH_JAL, J_type, 32'h00000008, 1'b0, 1);
    drain("final_drain");
    @(posedge clk); #1;
    chk("final_out_valid", 64'(out_valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
